// File: rtl/time_set_pkg.sv
// Shared types and constants for the time-setting sequencer.
package time_set_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] KEY_BACK = 4'd10;
    localparam logic [3:0] KEY_ADV  = 4'd11;
    localparam int         VAL_W    = 7;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_field_acc.sv
// Two-digit decimal accumulator for the field currently being typed.
module bcd_field_acc
    import time_set_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_digit_vld,
    input  logic [3:0]       i_digit,
    output logic [VAL_W-1:0] o_acc,
    output logic [1:0]       o_cnt,
    output logic             o_full
);

    logic [VAL_W-1:0] r_acc;
    logic [1:0]       r_cnt;
    logic             w_full;
    logic [VAL_W-1:0] w_acc_nxt;

    assign w_full    = (r_cnt == 2'd2);
    // acc holds at most 9 before the second digit, so the result never exceeds 99
    assign w_acc_nxt = r_acc * VAL_W'(10) + VAL_W'(i_digit);

    always_ff @(posedge clock) begin
        if (reset || i_clr) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_digit_vld && !w_full) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + 2'd1;
        end
    end

    assign o_acc  = r_acc;
    assign o_cnt  = r_cnt;
    assign o_full = w_full;

endmodule

// File: rtl/time_set_seq.sv
// Keypad-driven sequencer that enters and commits NUM_FIELDS time fields in order.
module time_set_seq
    import time_set_pkg::*;
#(
    parameter int NUM_FIELDS  = 3,
    parameter int FIELD0_MAX  = 23,
    parameter int FIELDN_MAX  = 59,
    parameter int TIMEOUT_CYC = 1000,
    localparam int IDX_W      = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  key_valid,
    input  logic [3:0]            key_code,
    output logic [NUM_FIELDS-1:0] field_en,
    output logic                  busy,
    output logic                  wr_valid,
    output logic [IDX_W-1:0]      wr_idx,
    output logic [VAL_W-1:0]      wr_value,
    output logic                  complete,
    output logic                  err,
    output logic                  timeout
);

    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic [15:0]      r_timer, w_timer_nxt, w_timer_inc;
    logic [VAL_W-1:0] w_acc, w_max;
    logic [1:0]       w_cnt;
    logic             w_full, w_acc_clr, w_digit_vld;
    logic             w_wr_valid, w_complete, w_err, w_timeout;

    logic [NUM_FIELDS-1:0] r_field_en;
    logic                  r_busy, r_wr_valid, r_complete, r_err, r_timeout;
    logic [IDX_W-1:0]      r_wr_idx;
    logic [VAL_W-1:0]      r_wr_value;

    bcd_field_acc u_acc (
        .clock       (clock),
        .reset       (reset),
        .i_clr       (w_acc_clr),
        .i_digit_vld (w_digit_vld),
        .i_digit     (key_code),
        .o_acc       (w_acc),
        .o_cnt       (w_cnt),
        .o_full      (w_full)
    );

    assign w_max       = (r_idx == '0) ? VAL_W'(FIELD0_MAX) : VAL_W'(FIELDN_MAX);
    assign w_timer_inc = r_timer + 16'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_timer_nxt = r_timer;
        w_acc_clr   = 1'b0;
        w_digit_vld = 1'b0;
        w_wr_valid  = 1'b0;
        w_complete  = 1'b0;
        w_err       = 1'b0;
        w_timeout   = 1'b0;
        // start restarts from any state and swallows a coincident key
        if (start) begin
            w_state_nxt = ST_ENTRY;
            w_idx_nxt   = '0;
            w_timer_nxt = '0;
            w_acc_clr   = 1'b1;
        end else begin
            case (r_state)
                ST_ENTRY: begin
                    if (key_valid) begin
                        w_timer_nxt = '0;
                        if (is_digit(key_code)) begin
                            w_digit_vld = !w_full;
                        end else if (key_code == KEY_BACK) begin
                            if (w_cnt != 2'd0) w_acc_clr = 1'b1;
                            else if (r_idx != '0) w_idx_nxt = r_idx - 1'b1;
                        end else if (key_code == KEY_ADV) begin
                            w_acc_clr = 1'b1;
                            if (w_acc <= w_max) begin
                                w_wr_valid = 1'b1;
                                if (r_idx == IDX_W'(NUM_FIELDS - 1)) begin
                                    w_complete  = 1'b1;
                                    w_state_nxt = ST_DONE;
                                    w_idx_nxt   = '0;
                                end else begin
                                    w_idx_nxt = r_idx + 1'b1;
                                end
                            end else begin
                                w_err = 1'b1;
                            end
                        end
                    end else if (w_timer_inc == 16'(TIMEOUT_CYC - 1)) begin
                        w_timeout   = 1'b1;
                        w_state_nxt = ST_IDLE;
                        w_idx_nxt   = '0;
                        w_timer_nxt = '0;
                        w_acc_clr   = 1'b1;
                    end else begin
                        w_timer_nxt = w_timer_inc;
                    end
                end
                ST_DONE: w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Output register stage: everything visible reflects the next-state decision
    always_ff @(posedge clock) begin
        if (reset) begin
            r_field_en <= '0;
            r_busy     <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_idx   <= '0;
            r_wr_value <= '0;
            r_complete <= 1'b0;
            r_err      <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_field_en <= (w_state_nxt == ST_ENTRY) ? (NUM_FIELDS'(1) << w_idx_nxt) : '0;
            r_busy     <= (w_state_nxt == ST_ENTRY);
            r_wr_valid <= w_wr_valid;
            r_wr_idx   <= w_wr_valid ? r_idx : '0;
            r_wr_value <= w_wr_valid ? w_acc : '0;
            r_complete <= w_complete;
            r_err      <= w_err;
            r_timeout  <= w_timeout;
        end
    end

    assign field_en = r_field_en;
    assign busy     = r_busy;
    assign wr_valid = r_wr_valid;
    assign wr_idx   = r_wr_idx;
    assign wr_value = r_wr_value;
    assign complete = r_complete;
    assign err      = r_err;
    assign timeout  = r_timeout;

endmodule

// File: tb/tb_time_set_seq.sv
// Directed bench for time_set_seq: main session flows plus a short-timeout instance.
module tb_time_set_seq;

    logic       clock = 1'b0;
    logic       reset, start, key_valid;
    logic [3:0] key_code;
    logic [2:0] field_en;
    logic       busy, wr_valid, complete, err, timeout;
    logic [1:0] wr_idx;
    logic [6:0] wr_value;

    logic       t_start, t_key_valid;
    logic [3:0] t_key_code;
    logic [2:0] t_field_en;
    logic       t_busy, t_wr_valid, t_complete, t_err, t_timeout;
    logic [1:0] t_wr_idx;
    logic [6:0] t_wr_value;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    time_set_seq #(.NUM_FIELDS(3), .FIELD0_MAX(23), .FIELDN_MAX(59), .TIMEOUT_CYC(1000)) u_dut (
        .clock(clock), .reset(reset), .start(start), .key_valid(key_valid), .key_code(key_code),
        .field_en(field_en), .busy(busy), .wr_valid(wr_valid), .wr_idx(wr_idx),
        .wr_value(wr_value), .complete(complete), .err(err), .timeout(timeout)
    );

    time_set_seq #(.NUM_FIELDS(3), .FIELD0_MAX(23), .FIELDN_MAX(59), .TIMEOUT_CYC(8)) u_dut_to (
        .clock(clock), .reset(reset), .start(t_start), .key_valid(t_key_valid), .key_code(t_key_code),
        .field_en(t_field_en), .busy(t_busy), .wr_valid(t_wr_valid), .wr_idx(t_wr_idx),
        .wr_value(t_wr_value), .complete(t_complete), .err(t_err), .timeout(t_timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic press(input logic [3:0] code);
        key_valid = 1'b1;
        key_code  = code;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_wr(input string tag, input logic [1:0] idx, input logic [6:0] val);
        check({tag, "_vld"}, wr_valid, 1);
        check({tag, "_idx"}, wr_idx, idx);
        check({tag, "_val"}, wr_value, val);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; key_valid = 1'b0; key_code = 4'd0;
        t_start = 1'b0; t_key_valid = 1'b0; t_key_code = 4'd0;
        tick(); tick();
        reset = 1'b0;
        check("rst_field_en", field_en, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_complete", complete, 0);
        check("rst_err", err, 0);
        check("rst_timeout", timeout, 0);

        // Full three-field session
        go();
        check("s1_field_en0", field_en, 3'b001);
        check("s1_busy", busy, 1);
        press(4'd1); press(4'd2);
        check("s1_no_wr", wr_valid, 0);
        press(4'd11);
        check_wr("s1_wr0", 2'd0, 7'd12);
        check("s1_field_en1", field_en, 3'b010);
        check("s1_nocomp0", complete, 0);
        press(4'd3); press(4'd0); press(4'd11);
        check_wr("s1_wr1", 2'd1, 7'd30);
        check("s1_field_en2", field_en, 3'b100);
        press(4'd4); press(4'd5); press(4'd11);
        check_wr("s1_wr2", 2'd2, 7'd45);
        check("s1_complete", complete, 1);
        check("s1_field_en_off", field_en, 3'b000);
        check("s1_busy_off", busy, 0);
        tick();
        check("s1_complete_pulse", complete, 0);
        check("s1_wr_pulse", wr_valid, 0);

        // Out-of-range hour rejected, then accepted value
        go();
        press(4'd2); press(4'd5); press(4'd11);
        check("s2_err", err, 1);
        check("s2_no_wr", wr_valid, 0);
        check("s2_field_en", field_en, 3'b001);
        tick();
        check("s2_err_pulse", err, 0);
        press(4'd0); press(4'd9); press(4'd11);
        check_wr("s2_wr0", 2'd0, 7'd9);
        check("s2_field_en1", field_en, 3'b010);

        // Back key: step back a field, then clear a partial entry
        press(4'd10);
        check("s3_back_field", field_en, 3'b001);
        press(4'd7); press(4'd10); press(4'd11);
        check_wr("s3_wr0", 2'd0, 7'd0);
        press(4'd10); press(4'd10);
        check("s3_back_floor", field_en, 3'b001);
        press(4'd11);
        check_wr("s3_wr0b", 2'd0, 7'd0);

        // start with a coincident key restarts and drops the key
        press(4'd3);
        start = 1'b1; key_valid = 1'b1; key_code = 4'd5;
        tick();
        start = 1'b0; key_valid = 1'b0;
        check("s4_restart_en", field_en, 3'b001);
        check("s4_restart_busy", busy, 1);
        press(4'd11);
        check_wr("s4_wr0", 2'd0, 7'd0);

        // Ignored codes and third digit
        press(4'd1); press(4'd2); press(4'd11);
        check_wr("s5_wr1", 2'd1, 7'd12);
        press(4'd1); press(4'd13);
        check("s5_ignored_en", field_en, 3'b100);
        check("s5_ignored_err", err, 0);
        press(4'd2); press(4'd3); press(4'd11);
        check_wr("s5_wr2", 2'd2, 7'd12);
        check("s5_complete", complete, 1);
        tick();

        // Range boundaries
        go();
        press(4'd2); press(4'd4); press(4'd11);
        check("s6_err24", err, 1);
        press(4'd2); press(4'd3); press(4'd11);
        check_wr("s6_wr23", 2'd0, 7'd23);
        press(4'd6); press(4'd0); press(4'd11);
        check("s6_err60", err, 1);
        press(4'd5); press(4'd9); press(4'd11);
        check_wr("s6_wr59", 2'd1, 7'd59);
        press(4'd9); press(4'd9); press(4'd11);
        check("s6_err99", err, 1);
        check("s6_err99_en", field_en, 3'b100);

        // Reset mid-session beats start and key
        press(4'd4);
        reset = 1'b1; start = 1'b1; key_valid = 1'b1; key_code = 4'd11;
        tick();
        reset = 1'b0; start = 1'b0; key_valid = 1'b0;
        check("s7_rst_en", field_en, 0);
        check("s7_rst_busy", busy, 0);
        check("s7_rst_wr", wr_valid, 0);
        check("s7_rst_err", err, 0);
        check("s7_rst_comp", complete, 0);
        go();
        press(4'd11);
        check_wr("s7_wr0", 2'd0, 7'd0);

        // Inactivity timeout with TIMEOUT_CYC=8
        t_start = 1'b1; tick(); t_start = 1'b0;
        check("t_busy", t_busy, 1);
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("t_early", t_timeout, 0);
        end
        tick();
        check("t_timeout", t_timeout, 1);
        check("t_busy_off", t_busy, 0);
        check("t_en_off", t_field_en, 0);
        check("t_no_wr", t_wr_valid, 0);
        check("t_no_comp", t_complete, 0);
        tick();
        check("t_pulse", t_timeout, 0);

        // Key arriving on the expiry cycle wins and restarts the timer
        t_start = 1'b1; tick(); t_start = 1'b0;
        for (int k = 1; k <= 6; k++) tick();
        t_key_valid = 1'b1; t_key_code = 4'd5;
        tick();
        t_key_valid = 1'b0;
        check("t_key_wins", t_timeout, 0);
        check("t_key_busy", t_busy, 1);
        for (int k = 1; k <= 6; k++) tick();
        check("t_rearm_early", t_timeout, 0);
        tick();
        check("t_rearm", t_timeout, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
